// File: rtl/receive.sv
// ---------------------------------------------------------------------------
// receive -- RMII (2-bit, 50 MHz) game-state frame receiver
//
// Finds the preamble/SFD, rebuilds bytes from LSB-first dibits, filters on the
// destination MAC (broadcast or MY_MAC), checks the Ethernet CRC-32 and pulls
// the 40-bit game payload out of data bytes 14..18. A complete, addressed,
// CRC-clean frame of exactly FRAME_BYTES updates the payload outputs and pulses
// rx_valid; any other frame that got past a good SFD pulses rx_err.
//
// Ports
//   eth_clk       in   1   RMII reference clock (sole clock)
//   eth_rst       in   1   asynchronous active-low reset
//   eth_crsdv     in   1   RMII carrier-sense / data-valid
//   eth_rxd       in   2   RMII receive dibit
//   rx_player_x   out  11  remote player x
//   rx_player_y   out  11  remote player y
//   rx_direction  out  9   remote heading
//   rx_game_stat  out  3   remote game status
//   rx_valid      out  1   one-cycle pulse: payload outputs just updated
//   rx_err        out  1   one-cycle pulse: frame rejected after a good SFD
//   rx_crc_ok     out  1   CRC result of the last evaluated frame
// ---------------------------------------------------------------------------
module receive #(
  parameter logic [47:0] MY_MAC      = 48'h02_00_00_00_00_01,
  parameter int          FRAME_BYTES = 56,
  parameter int          MIN_PRE     = 8,
  parameter bit          CHECK_FCS   = 1'b1
) (
  input  logic        eth_clk,
  input  logic        eth_rst,
  input  logic        eth_crsdv,
  input  logic [1:0]  eth_rxd,
  output logic [10:0] rx_player_x,
  output logic [10:0] rx_player_y,
  output logic [8:0]  rx_direction,
  output logic [2:0]  rx_game_stat,
  output logic        rx_valid,
  output logic        rx_err,
  output logic        rx_crc_ok
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_BODY = 3'd2;
  localparam logic [2:0] S_EVAL = 3'd3;
  localparam logic [2:0] S_DROP = 3'd4;

  localparam logic [7:0]  FB       = 8'(FRAME_BYTES);
  localparam logic [7:0]  FB_OVER  = 8'(FRAME_BYTES + 1);
  localparam logic [4:0]  MP       = 5'(MIN_PRE);
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
  // Residue left in an un-inverted CRC register after the FCS has been fed in.
  localparam logic [31:0] CRC_RES  = 32'hDEBB_20E3;

  logic [2:0]  state_reg;
  logic [4:0]  pre_cnt_reg;
  logic [1:0]  dibit_cnt_reg;
  logic [7:0]  byte_cnt_reg;
  logic [7:0]  byte_sr_reg;
  logic [47:0] dest_reg;
  logic [39:0] payload_reg;
  logic [31:0] crc_reg;

  logic [31:0] crc_half;
  logic [31:0] crc_next;
  logic [7:0]  full_byte;
  logic [7:0]  byte_cnt_next;
  logic        crc_ok;
  logic        addr_ok;
  logic        frame_good;

  // Two reflected CRC bit-steps per dibit, rxd[0] goes first on the wire.
  always_comb begin
    crc_half = (crc_reg[0] ^ eth_rxd[0]) ? ((crc_reg >> 1) ^ CRC_POLY) : (crc_reg >> 1);
    crc_next = (crc_half[0] ^ eth_rxd[1]) ? ((crc_half >> 1) ^ CRC_POLY) : (crc_half >> 1);
  end

  // Newest dibit lands in the top; on the 4th dibit the first one sits in bits[1:0].
  assign full_byte     = {eth_rxd, byte_sr_reg[7:2]};
  assign byte_cnt_next = byte_cnt_reg + 8'd1;

  assign crc_ok     = (crc_reg == CRC_RES);
  assign addr_ok    = (dest_reg == 48'hFFFF_FFFF_FFFF) || (dest_reg == MY_MAC);
  assign frame_good = (dibit_cnt_reg == 2'd0) && (byte_cnt_reg == FB) && addr_ok &&
                      (crc_ok || !CHECK_FCS);

  always_ff @(posedge eth_clk or negedge eth_rst) begin
    if (!eth_rst) begin
      state_reg     <= S_IDLE;
      pre_cnt_reg   <= '0;
      dibit_cnt_reg <= '0;
      byte_cnt_reg  <= '0;
      byte_sr_reg   <= '0;
      dest_reg      <= '0;
      payload_reg   <= '0;
      crc_reg       <= '0;
      rx_player_x   <= '0;
      rx_player_y   <= '0;
      rx_direction  <= '0;
      rx_game_stat  <= '0;
      rx_valid      <= 1'b0;
      rx_err        <= 1'b0;
      rx_crc_ok     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (eth_crsdv && eth_rxd == 2'b01) begin
            state_reg   <= S_PRE;
            pre_cnt_reg <= 5'd1;
          end
        end
        S_PRE: begin
          if (!eth_crsdv) begin
            state_reg <= S_IDLE;
          end else if (eth_rxd == 2'b01) begin
            if (pre_cnt_reg != 5'd31) pre_cnt_reg <= pre_cnt_reg + 5'd1;
          end else if (eth_rxd == 2'b11 && pre_cnt_reg >= MP) begin
            state_reg     <= S_BODY;
            dibit_cnt_reg <= '0;
            byte_cnt_reg  <= '0;
            crc_reg       <= 32'hFFFF_FFFF;
          end else begin
            // Short preamble or a bad dibit: line noise, not a frame.
            state_reg <= S_IDLE;
          end
        end
        S_BODY: begin
          if (!eth_crsdv) begin
            state_reg <= S_EVAL;
          end else begin
            crc_reg       <= crc_next;
            byte_sr_reg   <= full_byte;
            dibit_cnt_reg <= dibit_cnt_reg + 2'd1;
            if (dibit_cnt_reg == 2'd3) begin
              byte_cnt_reg <= byte_cnt_next;
              if (byte_cnt_reg < 8'd6)
                dest_reg <= {dest_reg[39:0], full_byte};
              if (byte_cnt_reg >= 8'd14 && byte_cnt_reg <= 8'd18)
                payload_reg <= {payload_reg[31:0], full_byte};
              if (byte_cnt_next == FB_OVER)
                state_reg <= S_DROP;
            end
          end
        end
        S_EVAL: begin
          state_reg <= S_IDLE;
          rx_crc_ok <= crc_ok;
          if (frame_good) begin
            rx_player_x  <= payload_reg[39:29];
            rx_player_y  <= payload_reg[27:17];
            rx_direction <= payload_reg[15:7];
            rx_game_stat <= payload_reg[3:1];
            rx_valid     <= 1'b1;
          end else begin
            rx_err <= 1'b1;
          end
        end
        S_DROP: begin
          if (!eth_crsdv) begin
            state_reg <= S_IDLE;
            rx_err    <= 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_receive.sv
// ---------------------------------------------------------------------------
// tb_receive -- directed self-checking bench for the RMII game-state receiver.
// Frames are assembled in a byte buffer (dest, src, len, payload, pad, FCS)
// and streamed out as RMII dibits after a 7x55 + D5 preamble/SFD.
// ---------------------------------------------------------------------------
module tb_receive;

  logic        eth_clk = 1'b0;
  logic        eth_rst = 1'b0;
  logic        eth_crsdv = 1'b0;
  logic [1:0]  eth_rxd = 2'b00;
  logic [10:0] rx_player_x;
  logic [10:0] rx_player_y;
  logic [8:0]  rx_direction;
  logic [2:0]  rx_game_stat;
  logic        rx_valid;
  logic        rx_err;
  logic        rx_crc_ok;

  receive dut (
    .eth_clk      (eth_clk),
    .eth_rst      (eth_rst),
    .eth_crsdv    (eth_crsdv),
    .eth_rxd      (eth_rxd),
    .rx_player_x  (rx_player_x),
    .rx_player_y  (rx_player_y),
    .rx_direction (rx_direction),
    .rx_game_stat (rx_game_stat),
    .rx_valid     (rx_valid),
    .rx_err       (rx_err),
    .rx_crc_ok    (rx_crc_ok)
  );

  always #10 eth_clk = ~eth_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  int both_cnt  = 0;
  int first_pulse;

  logic [7:0] frame [0:63];

  always @(negedge eth_clk) begin
    if (rx_valid) valid_cnt++;
    if (rx_err) err_cnt++;
    if (rx_valid && rx_err) both_cnt++;
  end

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [39:0] mk_payload(input int x, input int y, input int dir, input int stat);
    logic [10:0] xv; logic [10:0] yv; logic [8:0] dv; logic [2:0] sv;
    xv = 11'(x); yv = 11'(y); dv = 9'(dir); sv = 3'(stat);
    return {xv, 1'b0, yv, 1'b0, dv, 3'b000, sv, 1'b0};
  endfunction

  task automatic build_frame(input logic [47:0] dest, input logic [39:0] p);
    logic [31:0] c;
    for (int i = 0; i < 64; i++) frame[i] = 8'h00;
    for (int i = 0; i < 6; i++) frame[i] = dest[47 - 8*i -: 8];
    for (int i = 0; i < 6; i++) frame[6 + i] = 8'h10 + 8'(i);
    frame[12] = 8'h00;
    frame[13] = 8'h05;
    for (int i = 0; i < 5; i++) frame[14 + i] = p[39 - 8*i -: 8];
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 52; i++) c = crc_byte(c, frame[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) frame[52 + i] = c[8*i +: 8];
    for (int i = 56; i < 64; i++) frame[i] = 8'hA5;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int d = 0; d < 4; d++) begin
      @(negedge eth_clk);
      eth_crsdv = 1'b1;
      eth_rxd   = b[2*d +: 2];
    end
  endtask

  task automatic send_frame(input int nbytes, input bit finish);
    for (int i = 0; i < 8; i++) send_byte((i == 7) ? 8'hD5 : 8'h55);
    for (int i = 0; i < nbytes; i++) send_byte(frame[i]);
    if (finish) begin
      @(negedge eth_clk);
      eth_crsdv = 1'b0;
      eth_rxd   = 2'b00;
    end
    $display("[TB] frame sent: %0d bytes after SFD", nbytes);
  endtask

  // Watch a bounded window after crsdv drops; records the first pulse position.
  task automatic wait_window();
    first_pulse = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge eth_clk);
      if ((rx_valid || rx_err) && first_pulse == 0) first_pulse = i;
    end
  endtask

  task automatic clear_counts();
    valid_cnt = 0;
    err_cnt   = 0;
  endtask

  task automatic test_reset();
    eth_rst = 1'b0;
    repeat (3) @(negedge eth_clk);
    n_tests++; if (rx_player_x !== 11'd0) begin n_fail++; $display("FAIL reset_x: got %0d expected 0", rx_player_x); end
    n_tests++; if (rx_player_y !== 11'd0) begin n_fail++; $display("FAIL reset_y: got %0d expected 0", rx_player_y); end
    n_tests++; if (rx_direction !== 9'd0) begin n_fail++; $display("FAIL reset_dir: got %0d expected 0", rx_direction); end
    n_tests++; if ({rx_game_stat, rx_valid, rx_err, rx_crc_ok} !== 6'd0) begin n_fail++; $display("FAIL reset_flags: got %b expected 000000", {rx_game_stat, rx_valid, rx_err, rx_crc_ok}); end
    eth_rst = 1'b1;
    repeat (2) @(negedge eth_clk);
    $display("[TB] reset released");
  endtask

  task automatic test_broadcast();
    build_frame(48'hFFFF_FFFF_FFFF, mk_payload(100, 200, 270, 3));
    clear_counts();
    send_frame(56, 1'b1);
    wait_window();
    n_tests++; if (valid_cnt != 1 || err_cnt != 0) begin n_fail++; $display("FAIL bcast_pulses: got valid=%0d err=%0d expected valid=1 err=0", valid_cnt, err_cnt); end
    n_tests++; if (first_pulse != 2) begin n_fail++; $display("FAIL bcast_latency: got %0d expected 2", first_pulse); end
    n_tests++; if (rx_player_x !== 11'd100) begin n_fail++; $display("FAIL bcast_x: got %0d expected 100", rx_player_x); end
    n_tests++; if (rx_player_y !== 11'd200) begin n_fail++; $display("FAIL bcast_y: got %0d expected 200", rx_player_y); end
    n_tests++; if (rx_direction !== 9'd270) begin n_fail++; $display("FAIL bcast_dir: got %0d expected 270", rx_direction); end
    n_tests++; if (rx_game_stat !== 3'd3) begin n_fail++; $display("FAIL bcast_stat: got %0d expected 3", rx_game_stat); end
    n_tests++; if (rx_crc_ok !== 1'b1) begin n_fail++; $display("FAIL bcast_crc_ok: got %b expected 1", rx_crc_ok); end
  endtask

  task automatic test_bad_crc();
    build_frame(48'hFFFF_FFFF_FFFF, mk_payload(100, 200, 270, 3));
    frame[15] = frame[15] ^ 8'h04;
    clear_counts();
    send_frame(56, 1'b1);
    wait_window();
    n_tests++; if (valid_cnt != 0 || err_cnt != 1) begin n_fail++; $display("FAIL badcrc_pulses: got valid=%0d err=%0d expected valid=0 err=1", valid_cnt, err_cnt); end
    n_tests++; if (rx_player_x !== 11'd100 || rx_player_y !== 11'd200) begin n_fail++; $display("FAIL badcrc_hold: got x=%0d y=%0d expected x=100 y=200", rx_player_x, rx_player_y); end
    n_tests++; if (rx_crc_ok !== 1'b0) begin n_fail++; $display("FAIL badcrc_crc_ok: got %b expected 0", rx_crc_ok); end
  endtask

  task automatic test_dest_filter();
    build_frame(48'h02_00_00_00_00_02, mk_payload(9, 9, 9, 1));
    clear_counts();
    send_frame(56, 1'b1);
    wait_window();
    n_tests++; if (valid_cnt != 0 || err_cnt != 1) begin n_fail++; $display("FAIL other_mac_pulses: got valid=%0d err=%0d expected valid=0 err=1", valid_cnt, err_cnt); end
    n_tests++; if (rx_direction !== 9'd270) begin n_fail++; $display("FAIL other_mac_hold: got %0d expected 270", rx_direction); end
    build_frame(48'h02_00_00_00_00_01, mk_payload(5, 7, 1, 2));
    clear_counts();
    send_frame(56, 1'b1);
    wait_window();
    n_tests++; if (valid_cnt != 1 || err_cnt != 0) begin n_fail++; $display("FAIL my_mac_pulses: got valid=%0d err=%0d expected valid=1 err=0", valid_cnt, err_cnt); end
    n_tests++; if ({rx_player_x, rx_player_y, rx_direction, rx_game_stat} !== {11'd5, 11'd7, 9'd1, 3'd2}) begin n_fail++; $display("FAIL my_mac_payload: got %0d/%0d/%0d/%0d expected 5/7/1/2", rx_player_x, rx_player_y, rx_direction, rx_game_stat); end
  endtask

  task automatic test_length();
    build_frame(48'hFFFF_FFFF_FFFF, mk_payload(1, 2, 3, 4));
    clear_counts();
    send_frame(55, 1'b1);
    wait_window();
    n_tests++; if (valid_cnt != 0 || err_cnt != 1) begin n_fail++; $display("FAIL trunc_pulses: got valid=%0d err=%0d expected valid=0 err=1", valid_cnt, err_cnt); end
    clear_counts();
    send_frame(60, 1'b1);
    wait_window();
    n_tests++; if (valid_cnt != 0 || err_cnt != 1) begin n_fail++; $display("FAIL over_pulses: got valid=%0d err=%0d expected valid=0 err=1", valid_cnt, err_cnt); end
    n_tests++; if (rx_player_x !== 11'd5 || rx_game_stat !== 3'd2) begin n_fail++; $display("FAIL length_hold: got x=%0d stat=%0d expected x=5 stat=2", rx_player_x, rx_game_stat); end
  endtask

  task automatic test_short_preamble();
    build_frame(48'hFFFF_FFFF_FFFF, mk_payload(1000, 2000, 511, 7));
    clear_counts();
    for (int i = 0; i < 4; i++) begin
      @(negedge eth_clk); eth_crsdv = 1'b1; eth_rxd = 2'b01;
    end
    @(negedge eth_clk); eth_rxd = 2'b11;
    $display("[TB] short preamble noise sent");
    send_frame(56, 1'b1);
    wait_window();
    n_tests++; if (valid_cnt != 1 || err_cnt != 0) begin n_fail++; $display("FAIL shortpre_pulses: got valid=%0d err=%0d expected valid=1 err=0", valid_cnt, err_cnt); end
    n_tests++; if ({rx_player_x, rx_player_y, rx_direction, rx_game_stat} !== {11'd1000, 11'd2000, 9'd511, 3'd7}) begin n_fail++; $display("FAIL shortpre_payload: got %0d/%0d/%0d/%0d expected 1000/2000/511/7", rx_player_x, rx_player_y, rx_direction, rx_game_stat); end
  endtask

  task automatic test_back_to_back();
    clear_counts();
    build_frame(48'hFFFF_FFFF_FFFF, mk_payload(11, 22, 33, 1));
    send_frame(56, 1'b1);
    @(negedge eth_clk);
    build_frame(48'h02_00_00_00_00_01, mk_payload(44, 55, 66, 6));
    send_frame(56, 1'b1);
    wait_window();
    n_tests++; if (valid_cnt != 2 || err_cnt != 0) begin n_fail++; $display("FAIL b2b_pulses: got valid=%0d err=%0d expected valid=2 err=0", valid_cnt, err_cnt); end
    n_tests++; if ({rx_player_x, rx_player_y, rx_direction, rx_game_stat} !== {11'd44, 11'd55, 9'd66, 3'd6}) begin n_fail++; $display("FAIL b2b_payload: got %0d/%0d/%0d/%0d expected 44/55/66/6", rx_player_x, rx_player_y, rx_direction, rx_game_stat); end
  endtask

  task automatic test_reset_mid_frame();
    build_frame(48'hFFFF_FFFF_FFFF, mk_payload(300, 400, 90, 5));
    send_frame(20, 1'b0);
    #3 eth_rst = 1'b0;
    #1;
    n_tests++; if ({rx_player_x, rx_player_y, rx_direction, rx_game_stat, rx_crc_ok} !== 35'd0) begin n_fail++; $display("FAIL midrst_outputs: got x=%0d y=%0d dir=%0d stat=%0d crc_ok=%b expected all 0", rx_player_x, rx_player_y, rx_direction, rx_game_stat, rx_crc_ok); end
    @(negedge eth_clk);
    eth_crsdv = 1'b0;
    eth_rxd   = 2'b00;
    @(negedge eth_clk);
    eth_rst = 1'b1;
    @(negedge eth_clk);
    clear_counts();
    send_frame(56, 1'b1);
    wait_window();
    n_tests++; if (valid_cnt != 1 || err_cnt != 0) begin n_fail++; $display("FAIL midrst_pulses: got valid=%0d err=%0d expected valid=1 err=0", valid_cnt, err_cnt); end
    n_tests++; if ({rx_player_x, rx_player_y, rx_direction, rx_game_stat} !== {11'd300, 11'd400, 9'd90, 3'd5}) begin n_fail++; $display("FAIL midrst_payload: got %0d/%0d/%0d/%0d expected 300/400/90/5", rx_player_x, rx_player_y, rx_direction, rx_game_stat); end
    n_tests++; if (both_cnt != 0) begin n_fail++; $display("FAIL valid_err_overlap: got %0d expected 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_broadcast();
    test_bad_crc();
    test_dest_filter();
    test_length();
    test_short_preamble();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
